frame_filler: RTL and testbench

Frame filler: the producer stage that sits directly upstream of the ping-pong pixel buffer and writes one complete frame into its back buffer on every frame boundary.
- Watches VGA `vsync` for the start of vertical sync.
- On each new frame, walks every pixel address of the back buffer and writes an animated RGB332 test pattern through a valid/ready write port.
- Reports the frame count and overruns.

---
 rtl/vga_pkg.sv | 19 +
 rtl/frame_filler_pattern_gen.sv | 18 +
 rtl/frame_filler.sv | 142 ++++++++++++++
 tb/tb_frame_filler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/pixel-buffer types: RGB332 pixel, ping-pong buffer geometry and
// frame filler state encoding.
package vga_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam int PP_DEPTH = 768;
    localparam int PP_WIDTH = 32;

    typedef enum logic {
        IDLE,
        FILL
    } filler_state_t;

endpackage

// File: rtl/frame_filler_pattern_gen.sv
// Combinational animated test pattern: (x, y, frame) -> RGB332 pixel.
// Kept standalone so sprite/tile generators can be swapped in later.
module pattern_gen
    import vga_pkg::*;
(
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic [4:0] f,
    output rgb332_t    pix
);

    always_comb begin
        pix.r = x ^ f[2:0];
        pix.g = y;
        pix.b = f[4:3];
    end

endmodule

// File: rtl/frame_filler.sv
// Writes one test-pattern frame into the ping-pong back buffer per vsync falling edge.
// Optional FRAME_FILLER_CHECKSUM_EN adds a per-frame 16-bit sum of written pixels.
module frame_filler
    import vga_pkg::*;
#(
    parameter int DEPTH  = PP_DEPTH,
    parameter int WIDTH  = PP_WIDTH,
    parameter int ADDR_W = 10
) (
    input  logic              clk_25MHz,
    input  logic              rst,
    input  logic              vsync,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt,
    output logic              overrun
`ifdef FRAME_FILLER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int ROWS = DEPTH / WIDTH;
    localparam int X_W  = ($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3;
    localparam int Y_W  = ($clog2(ROWS) > 3) ? $clog2(ROWS) : 3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(WIDTH - 1);

    filler_state_t  state;
    logic           vsync_q;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           start;
    logic           accept;
    logic           last;
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;
    logic [4:0]     pf;
    rgb332_t        pix;

    assign start  = vsync_q & ~vsync;
    assign accept = wr_en & wr_ready;
    assign last   = accept && (wr_addr == LAST_ADDR);

    // Outputs are registered, so the pattern is evaluated for the pixel that
    // will be presented next: (0,0) with the incremented count at fill start,
    // otherwise the successor of the pixel currently on the port.
    always_comb begin
        px = '0;
        py = '0;
        pf = frame_cnt[4:0] + 5'd1;
        if (state == FILL) begin
            pf = frame_cnt[4:0];
            if (x == LAST_X) begin
                py = y + Y_W'(1);
            end else begin
                px = x + X_W'(1);
                py = y;
            end
        end
    end

    pattern_gen u_pattern_gen (
        .x   (px[2:0]),
        .y   (py[2:0]),
        .f   (pf),
        .pix (pix)
    );

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state     <= IDLE;
            vsync_q   <= 1'b1;
            x         <= '0;
            y         <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        x         <= px;
                        y         <= py;
                        wr_en     <= 1'b1;
                        wr_addr   <= '0;
                        wr_data   <= pix;
                        busy      <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                FILL: begin
                    // An edge coinciding with the final accept is simply dropped.
                    if (start && !last) begin
                        overrun <= 1'b1;
                    end
                    if (last) begin
                        state <= IDLE;
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (accept) begin
                        x       <= px;
                        y       <= py;
                        wr_addr <= wr_addr + ADDR_W'(1);
                        wr_data <= pix;
                    end
                end
            endcase
        end
    end

`ifdef FRAME_FILLER_CHECKSUM_EN
    logic [15:0] acc;

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            acc      <= '0;
            checksum <= '0;
        end else if (state == IDLE && start) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc + {8'h00, wr_data};
            if (last) begin
                checksum <= acc + {8'h00, wr_data};
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_filler.sv
// Directed bench for frame_filler: timing, pattern, backpressure, overrun,
// reset abort and frame counter wrap (checksum too when the macro is defined).
module tb_frame_filler;

    localparam int DEPTH = 768;
    localparam int WIDTH = 32;

    logic        clk_25MHz;
    logic        rst;
    logic        vsync;
    logic        wr_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [7:0]  frame_cnt;
    logic        overrun;
    logic [15:0] checksum;

    logic        w_vsync;
    logic        w_ready;
    logic        w_wr_en;
    logic [5:0]  w_addr;
    logic [7:0]  w_data;
    logic        w_busy;
    logic        w_done;
    logic [7:0]  w_cnt;
    logic        w_ovr;
    logic [15:0] w_cs;

    int checks = 0;
    int errors = 0;

    frame_filler #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(10)) dut (
        .clk_25MHz (clk_25MHz),
        .rst       (rst),
        .vsync     (vsync),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
`ifdef FRAME_FILLER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // Small geometry instance so 256 frames fit in a short run.
    frame_filler #(.DEPTH(64), .WIDTH(32), .ADDR_W(6)) dut_wrap (
        .clk_25MHz (clk_25MHz),
        .rst       (rst),
        .vsync     (w_vsync),
        .wr_ready  (w_ready),
        .wr_en     (w_wr_en),
        .wr_addr   (w_addr),
        .wr_data   (w_data),
        .busy      (w_busy),
        .done      (w_done),
        .frame_cnt (w_cnt),
        .overrun   (w_ovr)
`ifdef FRAME_FILLER_CHECKSUM_EN
        ,
        .checksum  (w_cs)
`endif
    );

`ifndef FRAME_FILLER_CHECKSUM_EN
    assign checksum = 16'h0000;
    assign w_cs     = 16'h0000;
`endif

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    function automatic logic [7:0] pat(input int a, input int width, input int f);
        int x;
        int y;
        x = a % width;
        y = a / width;
        return {3'((x ^ f) & 7), 3'(y & 7), 2'((f >> 3) & 3)};
    endfunction

    function automatic logic [15:0] model_sum(input int depth, input int width, input int f);
        logic [15:0] s;
        s = '0;
        for (int a = 0; a < depth; a++) s = s + {8'h00, pat(a, width, f)};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one fill on the main instance, starting at a negedge.
    task automatic fill(input int f, input int stall_at, input int edge_at,
                        input int rst_at, input logic exp_ovr);
        vsync = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk_25MHz);
            if (k == 1) vsync = 1'b1;
            chk("wr_en", wr_en, 1);
            chk("wr_addr", wr_addr, k);
            chk("wr_data", wr_data, pat(k, WIDTH, f));
            if (k == 0) begin
                chk("busy_start", busy, 1);
                chk("frame_cnt_start", frame_cnt, f & 255);
                chk("done_start", done, 0);
            end
            if (f == 1 && k == 0)   chk("pat_a0", wr_data, 8'h20);
            if (f == 1 && k == 33)  chk("pat_a33", wr_data, 8'h04);
            if (f == 1 && k == 767) chk("pat_a767", wr_data, 8'hDC);
            if (f == 2 && k == 100) chk("pat_f2_a100", wr_data, 8'hCC);
            if (k == DEPTH - 1) chk("done_before_last", done, 0);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk_25MHz);
                chk("rst_wr_en", wr_en, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frame_cnt", frame_cnt, 0);
                chk("rst_overrun", overrun, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_wr_data", wr_data, 0);
                chk("rst_done", done, 0);
                rst = 1'b0;
                return;
            end
            if (k == stall_at) begin
                wr_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk_25MHz);
                    chk("stall_wr_en", wr_en, 1);
                    chk("stall_addr", wr_addr, k);
                    chk("stall_data", wr_data, pat(k, WIDTH, f));
                end
                wr_ready = 1'b1;
            end
            if (k == edge_at) vsync = 1'b0;
            if (k == edge_at + 2) vsync = 1'b1;
        end
        @(negedge clk_25MHz);
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("wr_en_end", wr_en, 0);
        chk("frame_cnt_end", frame_cnt, f & 255);
        chk("overrun_end", overrun, exp_ovr);
`ifdef FRAME_FILLER_CHECKSUM_EN
        chk("checksum", checksum, model_sum(DEPTH, WIDTH, f));
`endif
        vsync = 1'b1;
        @(negedge clk_25MHz);
        chk("done_one_cycle", done, 0);
        chk("idle_wr_en", wr_en, 0);
    endtask

    initial begin
        logic seen;
        rst      = 1'b1;
        vsync    = 1'b1;
        wr_ready = 1'b1;
        w_vsync  = 1'b1;
        w_ready  = 1'b1;
        repeat (3) @(negedge clk_25MHz);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_overrun", overrun, 0);
`ifdef FRAME_FILLER_CHECKSUM_EN
        chk("reset_checksum", checksum, 0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk_25MHz);
        chk("idle_no_start", busy, 0);

        // Plain fill, then a 3-cycle stall at addr 100.
        fill(1, -1, -1, -1, 1'b0);
        fill(2, 100, -1, -1, 1'b0);

        // Edge on the final accept: no overrun, no new fill.
        fill(3, -1, DEPTH - 1, -1, 1'b0);
        repeat (2) @(negedge clk_25MHz);
        chk("edge_last_busy", busy, 0);
        chk("edge_last_cnt", frame_cnt, 3);
        chk("edge_last_ovr", overrun, 0);

        // Edge mid-fill: ignored but flagged as overrun (sticky).
        fill(4, -1, 400, -1, 1'b1);
        repeat (3) @(negedge clk_25MHz);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_cnt", frame_cnt, 4);

        // Reset abort at addr 200.
        fill(5, -1, -1, 200, 1'b0);
        @(negedge clk_25MHz);
        chk("post_rst_idle", wr_en, 0);

        // Counter wrap over 256 frames on the small instance.
        for (int f = 1; f <= 256; f++) begin
            w_vsync = 1'b0;
            @(negedge clk_25MHz);
            w_vsync = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk_25MHz);
                if (w_done) seen = 1'b1;
            end
            chk("wrap_done", seen, 1);
            chk("wrap_cnt", w_cnt, f & 255);
`ifdef FRAME_FILLER_CHECKSUM_EN
            chk("wrap_checksum", w_cs, model_sum(64, 32, f));
`endif
        end
        chk("wrap_overrun", w_ovr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
